csr_file: RTL

- Machine-mode CSR storage for the RV32I core.
- Consumer end of the writeback CSR path: registers the csr address/enable/data leaving the mem/wb stage, and answers CSR reads issued by the decode stage.
- WB→ID bypass for same-cycle address matches.
- Holds the 64-bit cycle and instret counters; exports mtvec/mepc for the trap/return path.

---
 rtl/csr_file.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR storage for the RV32I core.
// Takes the CSR write leaving mem/wb, answers decode-stage CSR reads
// with a WB->ID bypass, and keeps the 64-bit cycle/instret counters.
module csr_file #(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        retire_in,
  input  logic        csr_write_enable_in,
  input  logic [11:0] csr_write_address_in,
  input  logic [31:0] csr_write_data_in,
  input  logic [11:0] csr_read_address_in,
  output logic [31:0] csr_read_data_out,
  output logic        csr_read_illegal_out,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  logic [31:0] wr_masked;
  logic        wr_ok;
  logic        wr_fire;
  logic [31:0] rd_value;
  logic        rd_illegal;
  logic [31:0] mstatus_value;

  assign mstatus_value = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
  assign wr_fire       = rdy_in && csr_write_enable_in && wr_ok;

  // Apply WARL masks to WB data and flag whether the address is writable.
  always_comb begin
    wr_masked = csr_write_data_in;
    wr_ok     = 1'b1;
    case (csr_write_address_in)
      A_MSTATUS:   wr_masked = (csr_write_data_in & 32'h0000_0088) | 32'h0000_1800;
      A_MIE:       wr_masked = csr_write_data_in & 32'h0000_0888;
      A_MTVEC:     wr_masked = csr_write_data_in & 32'hFFFF_FFFD;
      A_MEPC:      wr_masked = csr_write_data_in & 32'hFFFF_FFFC;
      A_MSCRATCH, A_MCAUSE, A_MTVAL,
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: wr_masked = csr_write_data_in;
      default: begin
        wr_masked = 32'd0;
        wr_ok     = 1'b0;
      end
    endcase
  end

  // Trap-related registers: store masked WB data when ready.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= 32'd0;
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mtval_q        <= 32'd0;
    end else if (wr_fire) begin
      case (csr_write_address_in)
        A_MSTATUS: begin
          mstatus_mie_q  <= wr_masked[3];
          mstatus_mpie_q <= wr_masked[7];
        end
        A_MIE:      mie_q      <= wr_masked;
        A_MTVEC:    mtvec_q    <= wr_masked;
        A_MSCRATCH: mscratch_q <= wr_masked;
        A_MEPC:     mepc_q     <= wr_masked;
        A_MCAUSE:   mcause_q   <= wr_masked;
        A_MTVAL:    mtval_q    <= wr_masked;
        default: ;
      endcase
    end
  end

  // Cycle counter: a write to either half replaces that cycle's increment.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mcycle_q <= 64'd0;
    end else if (rdy_in) begin
      if (wr_fire && csr_write_address_in == A_MCYCLE)
        mcycle_q[31:0] <= wr_masked;
      else if (wr_fire && csr_write_address_in == A_MCYCLEH)
        mcycle_q[63:32] <= wr_masked;
      else
        mcycle_q <= mcycle_q + 64'd1;
    end
  end

  // Retired-instruction counter, same write-wins rule as the cycle counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      minstret_q <= 64'd0;
    end else if (rdy_in) begin
      if (wr_fire && csr_write_address_in == A_MINSTRET)
        minstret_q[31:0] <= wr_masked;
      else if (wr_fire && csr_write_address_in == A_MINSTRETH)
        minstret_q[63:32] <= wr_masked;
      else if (retire_in)
        minstret_q <= minstret_q + 64'd1;
    end
  end

  // Decode-stage read mux with WB bypass for writable CSRs.
  always_comb begin
    rd_value   = 32'd0;
    rd_illegal = 1'b0;
    case (csr_read_address_in)
      A_MSTATUS:               rd_value = mstatus_value;
      A_MISA:                  rd_value = MISA_VALUE;
      A_MIE:                   rd_value = mie_q;
      A_MTVEC:                 rd_value = mtvec_q;
      A_MSCRATCH:              rd_value = mscratch_q;
      A_MEPC:                  rd_value = mepc_q;
      A_MCAUSE:                rd_value = mcause_q;
      A_MTVAL:                 rd_value = mtval_q;
      A_MIP:                   rd_value = 32'd0;
      A_MHARTID:               rd_value = HART_ID;
      A_MCYCLE, A_CYCLE:       rd_value = mcycle_q[31:0];
      A_MCYCLEH, A_CYCLEH:     rd_value = mcycle_q[63:32];
      A_MINSTRET, A_INSTRET:   rd_value = minstret_q[31:0];
      A_MINSTRETH, A_INSTRETH: rd_value = minstret_q[63:32];
      default:                 rd_illegal = 1'b1;
    endcase
    if (wr_fire && csr_write_address_in == csr_read_address_in)
      rd_value = wr_masked;
  end

  assign csr_read_data_out    = rd_value;
  assign csr_read_illegal_out = rd_illegal;
  assign mtvec_out            = mtvec_q;
  assign mepc_out             = mepc_q;

endmodule
